// File: rtl/mas_alu_top.sv
// MAS ALU: request-driven integer unit (add, sub, logical shifts) built from
// a control FSM (mfsm) that gates a registered decode/datapath block (mdec).

`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

package mas_alu_pkg;
  parameter int MAS_BLEN = `MAS_BLEN;

  typedef enum logic [1:0] {
    MAS_ADD    = 2'd0,
    MAS_SUB    = 2'd1,
    MAS_RSHIFT = 2'd2,
    MAS_LSHIFT = 2'd3
  } type_mas_alu_cmd;

  typedef enum logic [1:0] {
    MAS_ALU_FSM_IDLE  = 2'd0,
    MAS_ALU_FSM_READY = 2'd1,
    MAS_ALU_FSM_OPER  = 2'd2
  } mas_alu_fsm_state_t;
endpackage

// Control FSM: IDLE -> READY -> OPER while the request is held; any drop of
// the request returns to IDLE. Outputs are registered alongside the state.
module mas_alu_fsm
  import mas_alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mas_alu_req,
  output logic mas_alu_fsm_ready,
  output logic mas_alu_fsm_oper
);

  mas_alu_fsm_state_t mas_alu_fsm_state;

  // State and registered outputs advance together on each edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mas_alu_fsm_state <= MAS_ALU_FSM_IDLE;
      mas_alu_fsm_ready <= 1'b0;
      mas_alu_fsm_oper  <= 1'b0;
    end else begin
      case (mas_alu_fsm_state)
        MAS_ALU_FSM_IDLE: begin
          if (mas_alu_req) begin
            mas_alu_fsm_state <= MAS_ALU_FSM_READY;
            mas_alu_fsm_ready <= 1'b1;
            mas_alu_fsm_oper  <= 1'b0;
          end else begin
            mas_alu_fsm_state <= MAS_ALU_FSM_IDLE;
            mas_alu_fsm_ready <= 1'b0;
            mas_alu_fsm_oper  <= 1'b0;
          end
        end
        MAS_ALU_FSM_READY, MAS_ALU_FSM_OPER: begin
          if (mas_alu_req) begin
            mas_alu_fsm_state <= MAS_ALU_FSM_OPER;
            mas_alu_fsm_ready <= 1'b1;
            mas_alu_fsm_oper  <= 1'b1;
          end else begin
            mas_alu_fsm_state <= MAS_ALU_FSM_IDLE;
            mas_alu_fsm_ready <= 1'b0;
            mas_alu_fsm_oper  <= 1'b0;
          end
        end
        default: begin
          mas_alu_fsm_state <= MAS_ALU_FSM_IDLE;
          mas_alu_fsm_ready <= 1'b0;
          mas_alu_fsm_oper  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// Decode/datapath: samples command and operands on each OPER edge with the
// request still high, registers the result and a one-cycle ready strobe.
module mas_alu_dec
  import mas_alu_pkg::*;
#(
  parameter int BLEN = MAS_BLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mas_alu_req,
  input  logic            mas_alu_fsm_oper,
  input  type_mas_alu_cmd mas_alu_cmd,
  input  logic [BLEN-1:0] mas_alu_op1,
  input  logic [BLEN-1:0] mas_alu_op2,
  output logic [BLEN-1:0] mas_alu_res,
  output logic            mas_alu_ready
);

  localparam int SHW = $clog2(BLEN);

  logic            sample;
  logic            shift_big;
  logic [SHW-1:0]  shamt;
  logic [BLEN-1:0] alu_out;
  logic [BLEN-1:0] res_d, res_q;
  logic            ready_d, ready_q;

  // Any op2 bit above the in-range shift field means the shift clears all bits.
  assign shift_big = |mas_alu_op2[BLEN-1:SHW];
  assign shamt     = mas_alu_op2[SHW-1:0];
  assign sample    = mas_alu_fsm_oper & mas_alu_req;

  // Combinational operation select.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    alu_out = '0;
    case (mas_alu_cmd)
      MAS_ADD:    alu_out = mas_alu_op1 + mas_alu_op2;
      MAS_SUB:    alu_out = mas_alu_op1 - mas_alu_op2;
      MAS_RSHIFT: alu_out = shift_big ? '0 : (mas_alu_op1 >> shamt);
      MAS_LSHIFT: alu_out = shift_big ? '0 : (mas_alu_op1 << shamt);
      default:    alu_out = '0;
    endcase
  end

  // Next-state: capture a new result only on sampling edges, otherwise hold.
  always_comb begin
    res_d   = res_q;
    ready_d = sample;
    if (sample) res_d = alu_out;
  end

  // Result and ready registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      ready_q <= ready_d;
    end
  end

  assign mas_alu_res   = res_q;
  assign mas_alu_ready = ready_q;

endmodule

// Top level: wires the control FSM to the datapath.
module mas_alu_top
  import mas_alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mas_alu_req,
  input  type_mas_alu_cmd     mas_alu_cmd,
  input  logic [MAS_BLEN-1:0] mas_alu_op1,
  input  logic [MAS_BLEN-1:0] mas_alu_op2,
  output logic [MAS_BLEN-1:0] mas_alu_res,
  output logic                mas_alu_ready
);

  logic mas_alu_fsm_ready;
  logic mas_alu_fsm_oper;

  mas_alu_fsm mfsm (
    .clk               (clk),
    .rst_n             (rst_n),
    .mas_alu_req       (mas_alu_req),
    .mas_alu_fsm_ready (mas_alu_fsm_ready),
    .mas_alu_fsm_oper  (mas_alu_fsm_oper)
  );

  mas_alu_dec #(.BLEN(MAS_BLEN)) mdec (
    .clk              (clk),
    .rst_n            (rst_n),
    .mas_alu_req      (mas_alu_req),
    .mas_alu_fsm_oper (mas_alu_fsm_oper),
    .mas_alu_cmd      (mas_alu_cmd),
    .mas_alu_op1      (mas_alu_op1),
    .mas_alu_op2      (mas_alu_op2),
    .mas_alu_res      (mas_alu_res),
    .mas_alu_ready    (mas_alu_ready)
  );

endmodule

// File: tb/tb_mas_alu_top.sv
// Scoreboard bench for mas_alu_top: the driver pushes model results when it
// issues an operation; a negedge monitor pops them whenever ready is high and
// checks that the result holds whenever ready is low.
module tb_mas_alu_top;
  import mas_alu_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                req;
  type_mas_alu_cmd     cmd;
  logic [MAS_BLEN-1:0] op1, op2;
  logic [MAS_BLEN-1:0] res;
  logic                ready;

  int total = 0;
  int bad   = 0;
  bit done  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_res;

  mas_alu_top dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mas_alu_req   (req),
    .mas_alu_cmd   (cmd),
    .mas_alu_op1   (op1),
    .mas_alu_op2   (op2),
    .mas_alu_res   (res),
    .mas_alu_ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input type_mas_alu_cmd c, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned m, x;
    m = 64'd1 << 32;
    case (c)
      MAS_ADD:    x = (longint'(a) + longint'(b)) % m;
      MAS_SUB:    x = (m + longint'(a) - longint'(b)) % m;
      MAS_RSHIFT: x = (b >= 32) ? 64'd0 : longint'(a) / (64'd1 << b);
      default:    x = (b >= 32) ? 64'd0 : (longint'(a) * (64'd1 << b)) % m;
    endcase
    return x[31:0];
  endfunction

  // Monitor: pop and compare on ready, otherwise the result must hold.
  initial begin
    while (!done) begin
      @(negedge clk);
      if (rst_n && !done) begin
        if (ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 32'(ready), 32'd0);
          end else begin
            model_res = exp_q.pop_front();
            check("res", res, model_res);
          end
        end else begin
          check("res_hold", res, model_res);
        end
      end
    end
  end

  // Present one operation for the next sampling edge.
  task automatic issue(input type_mas_alu_cmd c, input logic [31:0] a, input logic [31:0] b);
    cmd = c;
    op1 = a;
    op2 = b;
    exp_q.push_back(model(c, a, b));
    @(posedge clk);
    #1;
  endtask

  // Raise req from IDLE and walk through READY into OPER.
  task automatic start_session();
    req = 1'b1;
    @(posedge clk);
    #1;
    check("state_ready", 32'(dut.mfsm.mas_alu_fsm_state), 32'(MAS_ALU_FSM_READY));
    check("fsm_ready_in_ready", 32'(dut.mfsm.mas_alu_fsm_ready), 32'd1);
    check("fsm_oper_in_ready", 32'(dut.mfsm.mas_alu_fsm_oper), 32'd0);
    check("ready_before_oper", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    check("state_oper", 32'(dut.mfsm.mas_alu_fsm_state), 32'(MAS_ALU_FSM_OPER));
    check("fsm_oper_in_oper", 32'(dut.mfsm.mas_alu_fsm_oper), 32'd1);
    check("ready_entering_oper", 32'(ready), 32'd0);
  endtask

  task automatic end_session();
    req = 1'b0;
    cmd = type_mas_alu_cmd'($urandom_range(0, 3));
    op1 = $urandom;
    op2 = $urandom;
    @(posedge clk);
    #1;
    check("state_idle_after_drop", 32'(dut.mfsm.mas_alu_fsm_state), 32'(MAS_ALU_FSM_IDLE));
    check("ready_after_drop", 32'(ready), 32'd0);
    check("fsm_ready_after_drop", 32'(dut.mfsm.mas_alu_fsm_ready), 32'd0);
  endtask

  task automatic random_op();
    type_mas_alu_cmd c;
    logic [31:0] a, b;
    c = type_mas_alu_cmd'($urandom_range(0, 3));
    a = $urandom;
    if ((c == MAS_RSHIFT || c == MAS_LSHIFT) && $urandom_range(0, 3) != 0)
      b = $urandom_range(0, 33);
    else
      b = $urandom;
    issue(c, a, b);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req       = 1'b0;
    cmd       = MAS_ADD;
    op1       = '0;
    op2       = '0;
    model_res = '0;
    #2;
    check("reset_res", res, 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_state", 32'(dut.mfsm.mas_alu_fsm_state), 32'(MAS_ALU_FSM_IDLE));
    check("reset_fsm_ready", 32'(dut.mfsm.mas_alu_fsm_ready), 32'd0);
    check("reset_fsm_oper", 32'(dut.mfsm.mas_alu_fsm_oper), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_without_req", 32'(dut.mfsm.mas_alu_fsm_state), 32'(MAS_ALU_FSM_IDLE));

    // Directed corner cases.
    start_session();
    issue(MAS_ADD,    32'd5,          32'd7);
    issue(MAS_ADD,    32'hFFFF_FFFF,  32'd1);
    issue(MAS_SUB,    32'd3,          32'd5);
    issue(MAS_SUB,    32'd100,        32'd100);
    issue(MAS_RSHIFT, 32'h8000_0000,  32'd31);
    issue(MAS_LSHIFT, 32'd1,          32'd31);
    issue(MAS_LSHIFT, 32'hF,          32'd32);
    issue(MAS_RSHIFT, 32'hDEAD_BEEF,  32'd0);
    issue(MAS_LSHIFT, 32'hDEAD_BEEF,  32'd0);
    issue(MAS_RSHIFT, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    issue(MAS_LSHIFT, 32'hFFFF_FFFF,  32'h0000_0100);
    end_session();
    repeat (2) @(posedge clk);
    #1;

    // Randomized back-to-back sessions.
    for (int s = 0; s < 12; s++) begin
      int n;
      n = $urandom_range(3, 30);
      start_session();
      for (int i = 0; i < n; i++) random_op();
      end_session();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges, mid-operation.
    start_session();
    for (int i = 0; i < 5; i++) random_op();
    issue(MAS_ADD, 32'd1, 32'd1);
    check("pre_reset_res", res, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_res", res, 32'd0);
    check("async_reset_ready", 32'(ready), 32'd0);
    check("async_reset_state", 32'(dut.mfsm.mas_alu_fsm_state), 32'(MAS_ALU_FSM_IDLE));
    check("async_reset_fsm_ready", 32'(dut.mfsm.mas_alu_fsm_ready), 32'd0);
    exp_q.delete();
    model_res = '0;
    req = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A fresh session after reset still works.
    start_session();
    for (int i = 0; i < 10; i++) random_op();
    end_session();
    repeat (2) @(posedge clk);
    #1;

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
